// File: rtl/mem_arbiter_if.sv
// Client and memory request/response signals of the miss arbiter.
// master: the arbiter side (drives responses and the memory request).
// slave: the environment side (clients and memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_resp;
    logic [DATA_W-1:0] ic_data;
    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_resp;
    logic [DATA_W-1:0] dc_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_resp;
    logic [DATA_W-1:0] mem_data;

    modport master (
        input  ic_req, ic_addr, dc_req, dc_addr, mem_resp, mem_data,
        output ic_resp, ic_data, dc_resp, dc_data, mem_req, mem_addr
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_addr, mem_resp, mem_data,
        input  ic_resp, ic_data, dc_resp, dc_data, mem_req, mem_addr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache miss requests onto one memory port; returns the word as a 1-cycle resp pulse.
// Latency: grant visible 1 cycle after req; resp pulse 1 cycle after mem_resp; 3 cycles minimum per transaction.
// Backpressure: req/resp level handshake; clients hold req until resp, mem_req held until mem_resp.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_if.master   bus,
    output logic            busy,
    output logic            timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              grant_dc_q, grant_dc_d;  // 1: dcache owns the transaction
    logic              last_dc_q, last_dc_d;    // 1: last grant went to dcache
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_d;
    logic [DATA_W-1:0] ic_data_d, dc_data_d;
    logic              ic_resp_d, dc_resp_d;
    logic              pick_dc;
    logic [ADDR_W-1:0] pick_addr;

    // Round-robin pick: dcache wins alone or on a tie when icache was served last.
    always_comb begin
        pick_dc   = bus.dc_req && (!bus.ic_req || !last_dc_q);
        pick_addr = pick_dc ? bus.dc_addr : bus.ic_addr;
    end

    // Next-state and next-output logic for the IDLE -> REQ -> DONE transaction cycle.
    always_comb begin
        state_d    = state_q;
        grant_dc_d = grant_dc_q;
        last_dc_d  = last_dc_q;
        addr_d     = bus.mem_addr;
        cnt_d      = cnt_q;
        err_d      = timeout_err;
        ic_data_d  = bus.ic_data;
        dc_data_d  = bus.dc_data;
        ic_resp_d  = 1'b0;
        dc_resp_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ic_req || bus.dc_req) begin
                    grant_dc_d = pick_dc;
                    last_dc_d  = pick_dc;
                    addr_d     = {pick_addr[ADDR_W-1:2], 2'b00};
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_resp) begin
                    if (grant_dc_q) begin
                        dc_data_d = bus.mem_data;
                        dc_resp_d = 1'b1;
                    end else begin
                        ic_data_d = bus.mem_data;
                        ic_resp_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    // Saturating wait count; flag raised on the cycle it reaches the limit.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q >= CNT_MAX - 1'b1) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // No grant here so the served client can drop its request first.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs are derived from next-state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_dc_q   <= 1'b0;
            last_dc_q    <= 1'b0;
            cnt_q        <= '0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            bus.ic_resp  <= 1'b0;
            bus.dc_resp  <= 1'b0;
            bus.ic_data  <= '0;
            bus.dc_data  <= '0;
        end else begin
            state_q      <= state_d;
            grant_dc_q   <= grant_dc_d;
            last_dc_q    <= last_dc_d;
            cnt_q        <= cnt_d;
            timeout_err  <= err_d;
            busy         <= (state_d != S_IDLE);
            bus.mem_req  <= (state_d == S_REQ);
            bus.mem_addr <= addr_d;
            bus.ic_resp  <= ic_resp_d;
            bus.dc_resp  <= dc_resp_d;
            bus.ic_data  <= ic_data_d;
            bus.dc_data  <= dc_data_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Initiator side of the single-port memory req/resp interface. Arbitrates instruction-fetch and data-access miss requests onto one memory port.
- Holds the winning request stable until the memory responds, captures the returned word, and hands it back to the requester as a one-cycle response pulse.
- Sits between the icache/dcache miss logic and the main memory model.

Parameters:
ADDR_W, 32, address width of clients and memory port
DATA_W, 32, data word width
TIMEOUT_CYCLES, 64, cycles of mem_req without mem_resp before timeout_err is flagged (must be >= 2)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
ic_req  input  1  icache request; held high until ic_resp
ic_addr  input  ADDR_W  icache byte address; stable while ic_req high
ic_resp  output  1  one-cycle pulse: ic_data valid
ic_data  output  DATA_W  returned word for icache
dc_req  input  1  dcache request; held high until dc_resp
dc_addr  input  ADDR_W  dcache byte address; stable while dc_req high
dc_resp  output  1  one-cycle pulse: dc_data valid
dc_data  output  DATA_W  returned word for dcache
mem_req  output  1  memory request, held until mem_resp
mem_addr  output  ADDR_W  word-aligned memory address
mem_resp  input  1  memory response; may be combinational from mem_req
mem_data  input  DATA_W  memory word, valid when mem_resp high
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky timeout flag

Behaviour:
- Single clock. Reset is synchronous and active-low (rst_n sampled at posedge clk).
- Reset values:
  - state = IDLE; mem_req = 0; mem_addr = 0.
  - ic_resp = dc_resp = 0; ic_data = dc_data = 0.
  - busy = 0; timeout_err = 0; wait counter = 0.
  - last_grant = IC, so the dcache wins the first tie.
- All outputs are registered. mem_req is a function of state only: high exactly in REQ.
- FSM:
  - IDLE:
    - If neither request is high, stay in IDLE.
    - If exactly one request is high, grant that client.
    - If both are high, grant the client that is not last_grant, then update last_grant.
    - On a grant: mem_addr <= {addr[ADDR_W-1:2], 2'b00}; record grant id; go to REQ.
  - REQ:
    - mem_req = 1; mem_addr held stable; wait counter increments, saturating at TIMEOUT_CYCLES.
    - On mem_resp = 1: latch mem_data into the granted client's data register; clear the counter; go to DONE.
    - Client requests arriving during REQ are ignored; the client must keep holding them.
  - DONE:
    - mem_req = 0; the granted client's resp pulses for exactly one cycle; go to IDLE.
    - No new grant is made in DONE, so the just-served client has a cycle to drop its req.
- Latency:
  - Client req seen in IDLE at cycle t -> mem_req high from t+1.
  - mem_resp at cycle m -> client resp high at m+1 only -> next grant possible at m+2 at the earliest.
- Only the granted client's data register changes. The other client's data register holds its previous value.
- Timeout:
  - When the wait counter reaches TIMEOUT_CYCLES while in REQ, timeout_err <= 1 and stays set until reset.
  - The transaction is not aborted; the FSM keeps waiting in REQ.
- mem_resp while not in REQ is ignored: no state change, no data capture.
- Reset mid-transaction: everything returns to reset values on the next edge, mem_req drops, and no resp pulse is issued.
- Fairness: with both clients requesting continuously, grants alternate, so neither client waits more than one full transaction.

Test Plan:
- Reset, then ic_req=1 with ic_addr=0x0000_0013, bench memory responding 11 cycles after mem_req rises with 0xDEAD_BEEF -> mem_req high from cycle 1; mem_addr=0x0000_0010; ic_resp pulses once, one cycle after mem_resp; ic_data=0xDEAD_BEEF; dc_resp stays 0.
- ic_req and dc_req both raised in the same cycle right after reset (dc_addr=0x20, ic_addr=0x40) -> dcache served first (mem_addr=0x20), then icache (mem_addr=0x40); busy drops for exactly one cycle between the two transactions.
- Both clients requesting continuously for 4 transactions -> grant order DC, IC, DC, IC; each mem_req deasserts for exactly 2 cycles (DONE, IDLE) between transactions.
- Memory with combinational zero-latency response (mem_resp = mem_req) -> mem_req high for 1 cycle; resp 1 cycle later; total 3 cycles per transaction.
- mem_resp withheld for 70 cycles with TIMEOUT_CYCLES=64 -> timeout_err rises after the 64th REQ cycle; the transaction completes normally when mem_resp arrives; timeout_err remains 1 until rst_n=0.
- rst_n=0 asserted during REQ -> next cycle mem_req=0, busy=0, no ic_resp/dc_resp pulse; a spurious mem_resp in IDLE causes no capture and no state change.
